// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream
// Description : Byte-stream UART transmitter. Buffers an unthrottled
//               data/valid/last byte stream in an internal FIFO and sends
//               each byte as a start / DATA_WIDTH data (LSB first) / stop
//               frame. Flags the end of every stop bit that belongs to a
//               byte marked "last".
// Ports       : i_clk        - clock
//               i_rst        - synchronous active-high reset
//               i_data       - byte to transmit
//               i_valid      - write strobe, one byte per cycle when not full
//               i_last       - marks i_data as the final byte of a task
//               o_tx         - UART line, idles high
//               o_busy       - FIFO non-empty or frame in flight
//               o_full       - FIFO holds FIFO_DEPTH entries
//               o_overflow   - one-cycle pulse, a write was dropped
//               o_frame_done - one-cycle pulse, stop bit of a last byte ended
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream #(
   parameter int DATA_WIDTH  = 8,
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_last,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_frame_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int ADDR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int WORD_W       = DATA_WIDTH + 1;

   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_MAX   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_MAX    = BIT_W'(DATA_WIDTH - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_chk_baud
         $error("uart_tx_stream: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
         $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FIFO: {last, data} words, wrapping pointers, explicit occupancy count
   // ------------------------------------------------------------------------
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nx;
   logic [WORD_W-1:0] head;
   logic              wr_en;
   logic              pop;

   // Full comes from the registered count only, so a pop in the same cycle
   // never opens room for a write arriving while full.
   assign o_full = (count == FULL_COUNT);
   assign wr_en  = i_valid && !o_full;
   assign head   = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {i_last, i_data};
      end
   end

   always_comb begin
      count_nx = count;
      case ({wr_en, pop})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Transmit state machine
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BAUD_W-1:0]     baud_nx;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_nx;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] shift_nx;
   logic                  last_reg;
   logic                  last_nx;
   logic                  done_nx;
   logic                  tx_nx;
   logic                  busy_nx;
   logic                  baud_end;
   logic                  bit_end;

   assign baud_end = (baud_cnt == BAUD_MAX);
   assign bit_end  = (bit_cnt == BIT_MAX);

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      last_nx  = last_reg;
      pop      = 1'b0;
      done_nx  = 1'b0;

      case (state)
         IDLE: begin
            if (count != '0) begin
               pop      = 1'b1;
               shift_nx = head[DATA_WIDTH-1:0];
               last_nx  = head[DATA_WIDTH];
               baud_nx  = '0;
               state_nx = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_nx  = '0;
               shift_nx = shift >> 1;
               if (bit_end) begin
                  state_nx = STOP;
               end else begin
                  bit_nx = bit_cnt + 1'b1;
               end
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_nx = '0;
               done_nx = last_reg;
               // A queued word goes straight into its start bit, so
               // consecutive frames have no idle gap between them.
               if (count != '0) begin
                  pop      = 1'b1;
                  shift_nx = head[DATA_WIDTH-1:0];
                  last_nx  = head[DATA_WIDTH];
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Line level is registered from the next state so o_tx is glitch-free.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase

      busy_nx = (state_nx != IDLE) || (count_nx != '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         last_reg     <= 1'b0;
         o_tx         <= 1'b1;
         o_busy       <= 1'b0;
         o_overflow   <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_nx;
         baud_cnt     <= baud_nx;
         bit_cnt      <= bit_nx;
         shift        <= shift_nx;
         last_reg     <= last_nx;
         o_tx         <= tx_nx;
         o_busy       <= busy_nx;
         o_overflow   <= i_valid && o_full;
         o_frame_done <= done_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream
// Description : Directed self-checking bench for uart_tx_stream with
//               CLKS_PER_BIT = 10 and a 4-entry FIFO. Every cycle compares
//               {tx, busy, full, overflow, frame_done} against expectations
//               derived from the frame format and hand-computed cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

   localparam int CPB   = 10;
   localparam int FRAME = 10 * CPB;

   logic       i_clk;
   logic       i_rst;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_last;
   logic       o_tx;
   logic       o_busy;
   logic       o_full;
   logic       o_overflow;
   logic       o_frame_done;

   int vectors;
   int errors;

   logic [7:0] tb_bytes [8];

   uart_tx_stream #(
      .DATA_WIDTH  (8),
      .CLK_FREQ_HZ (1_000_000),
      .BAUD_RATE   (100_000),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .i_last       (i_last),
      .o_tx         (o_tx),
      .o_busy       (o_busy),
      .o_full       (o_full),
      .o_overflow   (o_overflow),
      .o_frame_done (o_frame_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Line level at offset t (0..FRAME-1) into the frame carrying byte b.
   function automatic logic frame_bit(input int t, input logic [7:0] b);
      if (t < CPB) return 1'b0;
      if (t < 9 * CPB) return b[(t - CPB) / CPB];
      return 1'b1;
   endfunction

   // Line level for n back-to-back frames of tb_bytes starting at cycle st.
   function automatic logic tx_model(input int c, input int st, input int n);
      int k;
      if (c < st) return 1'b1;
      k = (c - st) / FRAME;
      if (k >= n) return 1'b1;
      return frame_bit((c - st) % FRAME, tb_bytes[k]);
   endfunction

   // Advance to the next cycle; inputs are driven and outputs sampled 1 ns
   // after the rising edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Leaves the bench in the window of cycle 0: DUT idle, FIFO empty.
   task automatic do_reset();
      i_rst   = 1'b1;
      i_valid = 1'b0;
      step();
      i_rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'hEE;
      i_last  = 1'b1;
      step();
      obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
      vectors++;
      if (obs !== 5'b10000) begin
         errors++;
         $display("FAIL reset_state: got tx/busy/full/ovf/done=%b expected %b", obs, 5'b10000);
      end
      i_rst   = 1'b0;
      i_valid = 1'b0;
      step();
      obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
      vectors++;
      if (obs !== 5'b10000) begin
         errors++;
         $display("FAIL reset_write_ignored: got tx/busy/full/ovf/done=%b expected %b", obs, 5'b10000);
      end
   endtask

   task automatic test_single_byte();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      tb_bytes[0] = 8'hA5;
      for (int c = 0; c <= 110; c++) begin
         i_valid = (c == 0);
         i_data  = 8'hA5;
         i_last  = 1'b1;
         exp[4] = tx_model(c, 2, 1);
         exp[3] = (c >= 1) && (c <= 101);
         exp[2] = 1'b0;
         exp[1] = 1'b0;
         exp[0] = (c == 102);
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_byte cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      tb_bytes[0] = 8'h01;
      tb_bytes[1] = 8'h02;
      tb_bytes[2] = 8'h03;
      for (int c = 0; c <= 310; c++) begin
         i_valid = (c <= 2);
         i_data  = (c <= 2) ? tb_bytes[c] : 8'h00;
         i_last  = (c == 2);
         exp[4] = tx_model(c, 2, 3);
         exp[3] = (c >= 1) && (c <= 301);
         exp[2] = 1'b0;
         exp[1] = 1'b0;
         exp[0] = (c == 302);
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
   endtask

   task automatic test_overflow();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      for (int k = 0; k < 5; k++) tb_bytes[k] = 8'h10 + 8'(k);
      for (int c = 0; c <= 510; c++) begin
         i_valid = (c <= 5);
         i_data  = 8'h10 + 8'(c);
         i_last  = 1'b0;
         exp[4] = tx_model(c, 2, 5);
         exp[3] = (c >= 1) && (c <= 501);
         exp[2] = (c >= 5) && (c <= 101);
         exp[1] = (c == 6);
         exp[0] = 1'b0;
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL overflow cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
   endtask

   task automatic test_reset_abort();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      tb_bytes[0] = 8'hA5;
      tb_bytes[1] = 8'h3C;
      for (int c = 0; c <= 160; c++) begin
         i_rst   = (c == 40);
         i_valid = (c == 0) || (c == 1) || (c == 50);
         i_data  = (c == 0) ? 8'hA5 : (c == 1) ? 8'h5A : 8'h3C;
         i_last  = 1'b1;
         if (c <= 40) begin
            exp[4] = tx_model(c, 2, 1);
         end else if (c >= 52 && c <= 151) begin
            exp[4] = frame_bit(c - 52, tb_bytes[1]);
         end else begin
            exp[4] = 1'b1;
         end
         exp[3] = ((c >= 1) && (c <= 40)) || ((c >= 51) && (c <= 151));
         exp[2] = 1'b0;
         exp[1] = 1'b0;
         exp[0] = (c == 152);
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_abort cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
      i_rst = 1'b0;
   endtask

   task automatic test_zero_ones();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      tb_bytes[0] = 8'h00;
      tb_bytes[1] = 8'hFF;
      for (int c = 0; c <= 210; c++) begin
         i_valid = (c <= 1);
         i_data  = (c == 0) ? 8'h00 : 8'hFF;
         i_last  = 1'b0;
         exp[4] = tx_model(c, 2, 2);
         exp[3] = (c >= 1) && (c <= 201);
         exp[2] = 1'b0;
         exp[1] = 1'b0;
         exp[0] = 1'b0;
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL zero_ones cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
   endtask

   // FIFO fills to 4 during the first frame; a write lands on the first
   // frame's final stop cycle, where a pop also happens. The write must be
   // rejected and 0x66 must never appear on the line.
   task automatic test_full_with_pop();
      logic [4:0] obs;
      logic [4:0] exp;
      do_reset();
      tb_bytes[0] = 8'h11;
      tb_bytes[1] = 8'h22;
      tb_bytes[2] = 8'h33;
      tb_bytes[3] = 8'h44;
      tb_bytes[4] = 8'h55;
      for (int c = 0; c <= 610; c++) begin
         i_valid = (c <= 4) || (c == 101);
         i_data  = (c <= 4) ? tb_bytes[c] : 8'h66;
         i_last  = 1'b0;
         exp[4] = tx_model(c, 2, 5);
         exp[3] = (c >= 1) && (c <= 501);
         exp[2] = (c >= 5) && (c <= 101);
         exp[1] = (c == 102);
         exp[0] = 1'b0;
         obs = {o_tx, o_busy, o_full, o_overflow, o_frame_done};
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL full_with_pop cycle %0d: got tx/busy/full/ovf/done=%b expected %b", c, obs, exp);
         end
         step();
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_last  = 1'b0;
      step();
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_reset_abort();
      test_zero_ones();
      test_full_with_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
